// File: rtl/alu_unit_pkg.sv
// Shared definitions for the integer execute stage: widths, opcode encodings
// and the result-holding state type.
package alu_unit_pkg;

  localparam int ROB_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Encoding 0 and anything above OP_BGEU are undefined operations.
  localparam logic [OP_WIDTH-1:0] OP_ADD   = 6'd1;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 6'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND   = 6'd3;
  localparam logic [OP_WIDTH-1:0] OP_OR    = 6'd4;
  localparam logic [OP_WIDTH-1:0] OP_XOR   = 6'd5;
  localparam logic [OP_WIDTH-1:0] OP_SLL   = 6'd6;
  localparam logic [OP_WIDTH-1:0] OP_SRL   = 6'd7;
  localparam logic [OP_WIDTH-1:0] OP_SRA   = 6'd8;
  localparam logic [OP_WIDTH-1:0] OP_SLT   = 6'd9;
  localparam logic [OP_WIDTH-1:0] OP_SLTU  = 6'd10;
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'd11;
  localparam logic [OP_WIDTH-1:0] OP_ANDI  = 6'd12;
  localparam logic [OP_WIDTH-1:0] OP_ORI   = 6'd13;
  localparam logic [OP_WIDTH-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_WIDTH-1:0] OP_SLLI  = 6'd15;
  localparam logic [OP_WIDTH-1:0] OP_SRLI  = 6'd16;
  localparam logic [OP_WIDTH-1:0] OP_SRAI  = 6'd17;
  localparam logic [OP_WIDTH-1:0] OP_SLTI  = 6'd18;
  localparam logic [OP_WIDTH-1:0] OP_SLTIU = 6'd19;
  localparam logic [OP_WIDTH-1:0] OP_LUI   = 6'd20;
  localparam logic [OP_WIDTH-1:0] OP_AUIPC = 6'd21;
  localparam logic [OP_WIDTH-1:0] OP_JAL   = 6'd22;
  localparam logic [OP_WIDTH-1:0] OP_JALR  = 6'd23;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'd24;
  localparam logic [OP_WIDTH-1:0] OP_BNE   = 6'd25;
  localparam logic [OP_WIDTH-1:0] OP_BLT   = 6'd26;
  localparam logic [OP_WIDTH-1:0] OP_BGE   = 6'd27;
  localparam logic [OP_WIDTH-1:0] OP_BLTU  = 6'd28;
  localparam logic [OP_WIDTH-1:0] OP_BGEU  = 6'd29;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  // Reg-imm forms take their second operand from the immediate.
  function automatic logic is_imm_op(input logic [OP_WIDTH-1:0] op);
    return (op >= OP_ADDI) && (op <= OP_SLTIU);
  endfunction

endpackage

// File: rtl/alu_unit_alu_comb.sv
// Purely combinational RV32I datapath: result, branch outcome and resolved
// target from opcode and operands.
module alu_comb
  import alu_unit_pkg::*;
(
  input  logic [OP_WIDTH-1:0]   i_opcode,
  input  logic [DATA_WIDTH-1:0] i_vj,
  input  logic [DATA_WIDTH-1:0] i_vk,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [DATA_WIDTH-1:0] i_pc,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_taken,
  output logic [DATA_WIDTH-1:0] o_target
);

  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_pc_imm;
  logic [DATA_WIDTH-1:0] w_vj_imm;
  logic [4:0]            w_shamt;

  assign w_op_b   = is_imm_op(i_opcode) ? i_imm : i_vk;
  assign w_pc_imm = i_pc + i_imm;
  assign w_vj_imm = i_vj + i_imm;
  assign w_shamt  = w_op_b[4:0];

  always_comb begin
    o_result = '0;
    o_taken  = FALSE;
    o_target = '0;
    case (i_opcode)
      OP_ADD, OP_ADDI:   o_result = i_vj + w_op_b;
      OP_SUB:            o_result = i_vj - w_op_b;
      OP_AND, OP_ANDI:   o_result = i_vj & w_op_b;
      OP_OR,  OP_ORI:    o_result = i_vj | w_op_b;
      OP_XOR, OP_XORI:   o_result = i_vj ^ w_op_b;
      OP_SLL, OP_SLLI:   o_result = i_vj << w_shamt;
      OP_SRL, OP_SRLI:   o_result = i_vj >> w_shamt;
      OP_SRA, OP_SRAI:   o_result = $signed(i_vj) >>> w_shamt;
      OP_SLT, OP_SLTI:   o_result = {{(DATA_WIDTH-1){1'b0}}, $signed(i_vj) < $signed(w_op_b)};
      OP_SLTU, OP_SLTIU: o_result = {{(DATA_WIDTH-1){1'b0}}, i_vj < w_op_b};
      OP_LUI:            o_result = i_imm;
      OP_AUIPC:          o_result = w_pc_imm;
      OP_JAL: begin
        o_result = i_pc + 32'd4;
        o_taken  = TRUE;
        o_target = w_pc_imm;
      end
      OP_JALR: begin
        o_result = i_pc + 32'd4;
        o_taken  = TRUE;
        o_target = {w_vj_imm[DATA_WIDTH-1:1], 1'b0};
      end
      OP_BEQ:  begin o_taken = (i_vj == i_vk);                   o_target = w_pc_imm; end
      OP_BNE:  begin o_taken = (i_vj != i_vk);                   o_target = w_pc_imm; end
      OP_BLT:  begin o_taken = ($signed(i_vj) <  $signed(i_vk)); o_target = w_pc_imm; end
      OP_BGE:  begin o_taken = ($signed(i_vj) >= $signed(i_vk)); o_target = w_pc_imm; end
      OP_BLTU: begin o_taken = (i_vj <  i_vk);                   o_target = w_pc_imm; end
      OP_BGEU: begin o_taken = (i_vj >= i_vk);                   o_target = w_pc_imm; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Integer execute stage: accepts one issued op per cycle from the RS, holds a
// single result on the CDB until granted, and supports flush and global stall.
module alu_unit #(
  parameter int ROB_WIDTH  = alu_unit_pkg::ROB_WIDTH,
  parameter int DATA_WIDTH = alu_unit_pkg::DATA_WIDTH,
  parameter int OP_WIDTH   = alu_unit_pkg::OP_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic                  rdy_rs_in,
  input  logic [OP_WIDTH-1:0]   opcode_rs_in,
  input  logic [DATA_WIDTH-1:0] vj_rs_in,
  input  logic [DATA_WIDTH-1:0] vk_rs_in,
  input  logic [DATA_WIDTH-1:0] imm_rs_in,
  input  logic [DATA_WIDTH-1:0] pc_rs_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_rs_in,
  output logic                  idle_rs_out,
  input  logic                  cdb_gnt_in,
  output logic                  rdy_cdb_out,
  output logic [DATA_WIDTH-1:0] result_cdb_out,
  output logic [ROB_WIDTH-1:0]  rob_id_cdb_out,
  output logic                  br_taken_cdb_out,
  output logic [DATA_WIDTH-1:0] br_target_cdb_out
);

  import alu_unit_pkg::*;

  state_e                r_state;
  state_e                w_state_next;
  logic                  w_issue;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_taken;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] r_result;
  logic [ROB_WIDTH-1:0]  r_rob_id;
  logic                  r_taken;
  logic [DATA_WIDTH-1:0] r_target;

  alu_comb u_alu_comb (
    .i_opcode (opcode_rs_in),
    .i_vj     (vj_rs_in),
    .i_vk     (vk_rs_in),
    .i_imm    (imm_rs_in),
    .i_pc     (pc_rs_in),
    .o_result (w_result),
    .o_taken  (w_taken),
    .o_target (w_target)
  );

  // A granted result frees the holding register in the same cycle.
  assign idle_rs_out = (r_state == ST_IDLE) | ((r_state == ST_VALID) & cdb_gnt_in);
  assign w_issue     = rdy_in & rdy_rs_in & idle_rs_out;

  always_comb begin
    w_state_next = r_state;
    w_load       = FALSE;
    if (rdy_in) begin
      if (clr_in) begin
        w_state_next = ST_IDLE;
      end else if (w_issue) begin
        w_state_next = ST_VALID;
        w_load       = TRUE;
      end else if ((r_state == ST_VALID) && cdb_gnt_in) begin
        w_state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_rob_id <= '0;
      r_taken  <= FALSE;
      r_target <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_result <= w_result;
        r_rob_id <= rob_id_rs_in;
        r_taken  <= w_taken;
        r_target <= w_target;
      end
    end
  end

  assign rdy_cdb_out       = (r_state == ST_VALID);
  assign result_cdb_out    = r_result;
  assign rob_id_cdb_out    = r_rob_id;
  assign br_taken_cdb_out  = r_taken;
  assign br_target_cdb_out = r_target;

endmodule
